// File: rtl/xrv32i_test_harness.sv
// Self-test harness for xrv32i_soc: sequences the core reset, snapshots watched registers,
// runs a cycle watchdog and latches a sticky PASS/FAIL/TIMEOUT verdict shown on an LED.
module xrv32i_test_harness #(
    parameter int DATA_W     = 32,
    parameter int NUM_CH     = 3,
    parameter int DONE_CH    = 0,
    parameter int PASS_CH    = 1,
    parameter int PASS_VAL   = 1,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 30,
    parameter int BLINK_DIV  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     restart_i,
    input  logic [NUM_CH*DATA_W-1:0] watch_i,
    output logic                     core_rst_o,
    output logic [NUM_CH*DATA_W-1:0] snap_o,
    output logic [NUM_CH-1:0]        ch_upd_o,
    output logic [31:0]              cycles_o,
    output logic                     done_o,
    output logic                     pass_o,
    output logic [1:0]               status_o,
    output logic                     timeout_o,
    output logic                     led_o
);

    localparam int HOLD_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [31:0]        TMO_LAST   = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TMO
    } state_t;

    state_t               state, next_state;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [BLINK_W-1:0]   blink_cnt;
    logic [NUM_CH-1:0]    diff;
    logic                 end_hit, pass_hit, tmo_hit;

    // End condition looks at the registered snapshot, never at watch_i directly.
    always_comb begin
        end_hit  = snap_o[DONE_CH*DATA_W +: DATA_W] != '0;
        pass_hit = snap_o[PASS_CH*DATA_W +: DATA_W] == DATA_W'(PASS_VAL);
        tmo_hit  = (TIMEOUT != 0) && (cycles_o == TMO_LAST);
        diff     = '0;
        for (int k = 0; k < NUM_CH; k++)
            diff[k] = watch_i[k*DATA_W +: DATA_W] != snap_o[k*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_HOLD;
        else      state <= next_state;
    end

    always_comb begin
        // NOTE: default assignment first so every path drives next_state and no latch is inferred.
        next_state = state;
        if (restart_i) begin
            next_state = S_HOLD;
        end else begin
            case (state)
                S_HOLD: if (hold_cnt == HOLD_LAST) next_state = S_RUN;
                S_RUN: begin
                    if (end_hit)      next_state = pass_hit ? S_PASS : S_FAIL;
                    else if (tmo_hit) next_state = S_TMO;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        core_rst_o = 1'b1;
        done_o     = 1'b0;
        pass_o     = 1'b0;
        timeout_o  = 1'b0;
        status_o   = 2'd0;
        case (state)
            S_HOLD: core_rst_o = 1'b0;
            S_RUN:  status_o   = 2'd1;
            S_PASS: begin done_o = 1'b1; pass_o = 1'b1; status_o = 2'd2; end
            S_FAIL: begin done_o = 1'b1; status_o = 2'd3; end
            S_TMO:  begin done_o = 1'b1; timeout_o = 1'b1; status_o = 2'd3; end
            default: core_rst_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
            snap_o   <= '0;
            ch_upd_o <= '0;
            cycles_o <= '0;
        end else if (restart_i) begin
            hold_cnt <= '0;
            snap_o   <= '0;
            ch_upd_o <= '0;
            cycles_o <= '0;
        end else begin
            hold_cnt <= (state == S_HOLD && next_state == S_HOLD) ? hold_cnt + 1'b1 : '0;
            if (state == S_RUN) begin
                snap_o   <= watch_i;
                ch_upd_o <= diff;
                if (cycles_o != '1) cycles_o <= cycles_o + 32'd1;
            end else begin
                ch_upd_o <= '0;
            end
        end
    end

    // LED restarts its blink phase at 1 whenever a failing verdict is entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_o     <= 1'b0;
            blink_cnt <= '0;
        end else begin
            case (next_state)
                S_PASS: begin
                    led_o     <= 1'b1;
                    blink_cnt <= '0;
                end
                S_FAIL, S_TMO: begin
                    if (state != S_FAIL && state != S_TMO) begin
                        led_o     <= 1'b1;
                        blink_cnt <= '0;
                    end else if (blink_cnt == BLINK_LAST) begin
                        led_o     <= ~led_o;
                        blink_cnt <= '0;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
                default: begin
                    led_o     <= 1'b0;
                    blink_cnt <= '0;
                end
            endcase
        end
    end

endmodule
